// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between NUM_REQ writeback
// requesters; zero-fills the whole regfile after reset before granting anything.
module regfile_wr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]           write_addr,
    output logic [DATA_WIDTH-1:0]           write_data,
    output logic                            write_enable,
    output logic                            init_busy,
    output logic                            dbg_state
);
    // Handshake: a requester transfers on a cycle where req_valid[i] & req_ready[i];
    // req_ready is one-hot or zero and never asserts without the matching valid.

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W:0]          scan_idx;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic [DATA_WIDTH-1:0]   grant_data;

    // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!grant_vld && req_valid[scan_idx[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[IDX_W-1:0];
            end
        end
        grant_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        grant_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        req_ready = '0;
        case (state_q)
            S_CLEAR: begin
                waddr_d   = clr_cnt_q;
                wdata_d   = '0;
                we_d      = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Address 0 is hardwired zero: accept the request but suppress the write.
                if (grant_vld && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    waddr_d  = grant_addr;
                    wdata_d  = grant_data;
                    we_d     = |grant_addr;
                    rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
        end
    end

    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign write_enable = we_q;
    assign init_busy    = (state_q == S_CLEAR);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter, checked against a
// transaction-level model of grants and regfile contents.
module tb_regfile_wr_arbiter;
    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     write_addr;
    logic [DW-1:0]     write_data;
    logic              write_enable;
    logic              init_busy;
    logic              dbg_state;

    logic [N-1:0]      nc_valid;
    logic [N*AW-1:0]   nc_addr;
    logic [N*DW-1:0]   nc_data;
    logic [N-1:0]      nc_ready;
    logic [AW-1:0]     nc_waddr;
    logic [DW-1:0]     nc_wdata;
    logic              nc_we;
    logic              nc_busy;
    logic              nc_dbg;
    logic              nc_busy_seen = 1'b0;

    regfile_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .write_addr(write_addr), .write_data(write_data),
        .write_enable(write_enable), .init_busy(init_busy), .dbg_state(dbg_state)
    );

    regfile_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .req_valid(nc_valid), .req_addr(nc_addr), .req_data(nc_data),
        .req_ready(nc_ready), .write_addr(nc_waddr), .write_data(nc_wdata),
        .write_enable(nc_we), .init_busy(nc_busy), .dbg_state(nc_dbg)
    );

    // clock / reset-free variant monitor
    always #5 clk = ~clk;
    always @(negedge clk) if (nc_busy === 1'b1) nc_busy_seen = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // requester side state and model state
    logic          pend  [N];
    logic [AW-1:0] paddr [N];
    logic [DW-1:0] pdata [N];
    logic [DW-1:0] ref_rf [NREG];
    logic [DW-1:0] dut_rf [NREG];
    logic [AW+DW-1:0] exp_q[$];
    bit  m_clear;
    int  m_cnt;
    int  m_rr;
    int  last_grant;
    int  busy_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_addr[i*AW +: AW]  = paddr[i];
            req_data[i*DW +: DW]  = pdata[i];
        end
    endtask

    task automatic model_reset();
        m_clear = 1'b1;
        m_cnt   = 0;
        m_rr    = 0;
        exp_q.delete();
    endtask

    // One clock: called at a negedge, checks outputs, advances the model, returns at next negedge.
    task automatic cycle();
        int g;
        int i;
        logic [N-1:0] exp_ready;
        logic [AW+DW-1:0] e;
        drive_inputs();
        #1;
        g = -1;
        if (!m_clear && !rst) begin
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (g < 0 && pend[i]) g = i;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", req_ready, exp_ready);
        check("init_busy", init_busy, m_clear);
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("write_enable", write_enable, 0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", write_addr, e[AW+DW-1:DW]);
                check("write_data", write_data, e[DW-1:0]);
            end
            dut_rf[write_addr] = write_data;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            check("write_enable", write_enable, 1);
        end
        last_grant = g;
        if (rst) begin
            model_reset();
        end else if (m_clear) begin
            exp_q.push_back({AW'(m_cnt), {DW{1'b0}}});
            ref_rf[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NREG) m_clear = 1'b0;
        end else if (g >= 0) begin
            if (paddr[g] != '0) begin
                exp_q.push_back({paddr[g], pdata[g]});
                ref_rf[paddr[g]] = pdata[g];
            end
            m_rr = (g + 1) % N;
            pend[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        paddr[i] = a;
        pdata[i] = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic readback(input int a);
        check($sformatf("readback_%0d", a), dut_rf[a], ref_rf[a]);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
        end
        for (int a = 0; a < NREG; a++) begin
            dut_rf[a] = 32'hDEAD_BEEF;
            ref_rf[a] = 32'h1234_5678;
        end
        drive_inputs();
        nc_valid = 2'b01;
        nc_addr  = {5'd0, 5'd5};
        nc_data  = {32'd0, 32'h55};
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        // reset values
        check("rst_we", write_enable, 0);
        check("rst_addr", write_addr, 0);
        check("rst_data", write_data, 0);
        check("rst_busy", init_busy, 1);
        check("rst_ready", req_ready, 0);

        // test 1 (+ variant without CLEAR granting on the first cycle)
        rst = 1'b0;
        #1;
        check("nc_ready_first", nc_ready, 2'b01);
        check("nc_busy_first", nc_busy, 0);
        busy_n = 0;
        for (int k = 0; k < NREG + 2; k++) begin
            if (init_busy === 1'b1) busy_n++;
            cycle();
            if (k == 0) begin
                check("nc_we", nc_we, 1);
                check("nc_waddr", nc_waddr, 5);
                check("nc_wdata", nc_wdata, 32'h55);
                nc_valid = '0;
            end
        end
        check("busy_cycles", busy_n, NREG);
        for (int a = 0; a < NREG; a++) readback(a);

        // test 2: single request
        set_req(0, 5'd7, 32'd327);
        cycle();
        check("t2_grant", last_grant, 0);
        idle(2);
        check("t2_rb7", dut_rf[7], 327);

        // test 4: address 0 accepted but never written
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        cycle();
        check("t4_grant", last_grant, 1);
        idle(2);
        check("t4_rb0", dut_rf[0], 0);

        // test 3: alternation with both continuously valid
        for (int k = 0; k < 6; k++) begin
            if (!pend[0]) set_req(0, 5'd3, 32'd36827);
            if (!pend[1]) set_req(1, 5'd9, 32'd5);
            cycle();
            check("t3_alt", last_grant, k % 2);
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        idle(2);
        readback(3);
        readback(9);

        // test 5: reset during RUN with a pending request
        set_req(0, 5'd12, 32'hABC);
        rst = 1'b1;
        cycle();
        check("t5_ready_in_rst", req_ready, 0);
        cycle();
        check("t5_we_after_rst", write_enable, 0);
        pend[0] = 1'b0;
        rst = 1'b0;
        idle(NREG + 2);
        check("t5_rb7", dut_rf[7], 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    set_req(i, AW'($urandom_range(0, NREG - 1)), $urandom);
                end
            end
            cycle();
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        idle(2);
        for (int a = 0; a < NREG; a++) readback(a);
        check("nc_busy_never", nc_busy_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
